// File: rtl/led_change_monitor.sv
// LED-bus change monitor: timestamps every LED change into a FIFO and stops capturing at STOP_PATTERN.
// Optional macro LED_MON_SYNC_EN adds a two-flop input synchronizer for asynchronous LEDS.
module led_change_monitor #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int TS_WIDTH = 16,
    parameter logic [WIDTH-1:0] STOP_PATTERN = WIDTH'(8'b11100000)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WIDTH-1:0]             leds,
    input  logic                         enable,
    input  logic                         clear,
    output logic                         ev_valid,
    input  logic                         ev_ready,
    output logic [TS_WIDTH+WIDTH-1:0]    ev_data,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         done,
    output logic                         overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = TS_WIDTH + WIDTH;

    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_DONE} state_t;

    logic [WIDTH-1:0]    s_reg;
    logic [WIDTH-1:0]    prev_reg;
    state_t              state_reg;
    logic [TS_WIDTH-1:0] ts_reg;
    logic [AW:0]         count_reg;
    logic [AW-1:0]       wr_ptr_reg;
    logic [AW-1:0]       rd_ptr_reg;
    logic                overflow_reg;
    logic [DW-1:0]       mem [DEPTH];

    logic change;
    logic stop_hit;
    logic pop;
    logic push;
    logic full;

`ifdef LED_MON_SYNC_EN
    logic [WIDTH-1:0] meta_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= '0;
            s_reg    <= '0;
        end else begin
            meta_reg <= leds;
            s_reg    <= meta_reg;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_reg <= '0;
        end else begin
            s_reg <= leds;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_reg <= '0;
        end else begin
            prev_reg <= s_reg;
        end
    end

    assign change   = (s_reg != prev_reg) && (state_reg == ST_ARMED);
    assign stop_hit = change && (s_reg == STOP_PATTERN);
    assign full     = count_reg[AW];
    assign ev_valid = (count_reg != '0);
    assign pop      = ev_valid && ev_ready;
    // A full FIFO still takes the new event when the head leaves in the same cycle.
    assign push     = change && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            ts_reg       <= '0;
            count_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            overflow_reg <= 1'b0;
        end else if (clear) begin
            state_reg    <= ST_IDLE;
            ts_reg       <= '0;
            count_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + (AW+1)'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - (AW+1)'(1);
            end
            if (change && !push) begin
                overflow_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    ts_reg <= '0;
                    if (enable) begin
                        state_reg <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    // The stop event wins over a simultaneous disarm.
                    if (stop_hit) begin
                        state_reg <= ST_DONE;
                        ts_reg    <= ts_reg + TS_WIDTH'(1);
                    end else if (!enable) begin
                        state_reg <= ST_IDLE;
                        ts_reg    <= '0;
                    end else begin
                        ts_reg    <= ts_reg + TS_WIDTH'(1);
                    end
                end
                default: begin
                    state_reg <= ST_DONE;
                end
            endcase
        end
    end

    // Event storage carries no reset; the head is read combinationally for show-ahead output.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr_reg] <= {ts_reg, s_reg};
        end
    end

    assign ev_data  = ev_valid ? mem[rd_ptr_reg] : '0;
    assign count    = count_reg;
    assign done     = (state_reg == ST_DONE);
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_led_change_monitor.sv
// Self-checking bench for led_change_monitor: directed scenarios plus random traffic against a queue model.
// Two instances share stimulus; the second uses a 4-bit timestamp to exercise wrap-around.
module tb_led_change_monitor;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] leds;
    logic       enable;
    logic       clear;
    logic       ev_ready;

    logic        ev_valid,  ev_valid4;
    logic [23:0] ev_data;
    logic [11:0] ev_data4;
    logic [4:0]  count,     count4;
    logic        done,      done4;
    logic        overflow,  overflow4;

    int checks = 0;
    int errors = 0;

    led_change_monitor #(.WIDTH(8), .DEPTH(16), .TS_WIDTH(16), .STOP_PATTERN(8'hE0)) u_dut (
        .clk(clk), .rst_n(rst_n), .leds(leds), .enable(enable), .clear(clear),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data),
        .count(count), .done(done), .overflow(overflow)
    );

    led_change_monitor #(.WIDTH(8), .DEPTH(16), .TS_WIDTH(4), .STOP_PATTERN(8'hE0)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .leds(leds), .enable(enable), .clear(clear),
        .ev_valid(ev_valid4), .ev_ready(ev_ready), .ev_data(ev_data4),
        .count(count4), .done(done4), .overflow(overflow4)
    );

    always #5 clk = ~clk;

    // Reference model: events are (absolute cycle count since arming, LED value).
    typedef struct {
        int unsigned ts;
        logic [7:0]  v;
    } ev_t;

    ev_t         q[$];
    int unsigned m_ts;
    int          m_state;   // 0 idle, 1 armed, 2 done
    logic [7:0]  m_s;
    logic [7:0]  m_prev;
    bit          m_ovf;

    function automatic void model_reset();
        q.delete();
        m_ts    = 0;
        m_state = 0;
        m_s     = 8'h00;
        m_prev  = 8'h00;
        m_ovf   = 1'b0;
    endfunction

    function automatic void model_next();
        bit  do_pop;
        bit  chg;
        ev_t e;
        do_pop = (q.size() != 0) && ev_ready;
        chg    = (m_s != m_prev) && (m_state == 1);
        if (clear) begin
            q.delete();
            m_ovf   = 1'b0;
            m_state = 0;
            m_ts    = 0;
        end else begin
            if (do_pop) begin
                e = q.pop_front();
                $display("pop ts=%0d leds=%h", e.ts, e.v);
            end
            if (chg) begin
                if (q.size() < 16) begin
                    e.ts = m_ts;
                    e.v  = m_s;
                    q.push_back(e);
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (m_state == 0) begin
                m_ts = 0;
                if (enable) m_state = 1;
            end else if (m_state == 1) begin
                if (chg && m_s == 8'hE0) begin
                    m_state = 2;
                    m_ts    = m_ts + 1;
                end else if (!enable) begin
                    m_state = 0;
                    m_ts    = 0;
                end else begin
                    m_ts = m_ts + 1;
                end
            end
        end
        m_prev = m_s;
        m_s    = leds;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] exp16;
        logic [31:0] exp4;
        exp16 = 32'h0;
        exp4  = 32'h0;
        if (q.size() != 0) begin
            exp16 = ((q[0].ts % 65536) << 8) | 32'(q[0].v);
            exp4  = ((q[0].ts % 16) << 8) | 32'(q[0].v);
        end
        chk("ev_valid", 32'(ev_valid), 32'(q.size() != 0));
        chk("count",    32'(count),    32'(q.size()));
        chk("done",     32'(done),     32'(m_state == 2));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("ev_data",  32'(ev_data),  exp16);
        chk("ev_valid4", 32'(ev_valid4), 32'(q.size() != 0));
        chk("count4",    32'(count4),    32'(q.size()));
        chk("done4",     32'(done4),     32'(m_state == 2));
        chk("overflow4", 32'(overflow4), 32'(m_ovf));
        chk("ev_data4",  32'(ev_data4),  exp4);
    endtask

    task automatic check_reset_values();
        chk("rst_ev_valid", 32'(ev_valid), 32'h0);
        chk("rst_ev_data",  32'(ev_data),  32'h0);
        chk("rst_count",    32'(count),    32'h0);
        chk("rst_done",     32'(done),     32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);
        chk("rst_ev_data4", 32'(ev_data4), 32'h0);
    endtask

    task automatic step();
        model_next();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        leds     = 8'h00;
        enable   = 1'b0;
        clear    = 1'b0;
        ev_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        rst_n = 1'b1;

        // First event: 00 then 01 held; valid two edges after the change.
        enable = 1'b1;
        steps(3);
        leds = 8'h01;
        step();
        chk("first_latency_k", 32'(ev_valid), 32'h0);
        step();
        chk("first_latency_k1", 32'(ev_valid), 32'h1);
        chk("first_value", 32'(ev_data[7:0]), 32'h01);
        chk("first_count", 32'(count), 32'h1);
        steps(2);

        // Walking pattern to the stop value with the consumer draining.
        ev_ready = 1'b1;
        leds = 8'h03; steps(3);
        leds = 8'h07; steps(3);
        leds = 8'h0F; steps(3);
        leds = 8'h1F; steps(3);
        leds = 8'h3F; steps(3);
        leds = 8'h7F; steps(3);
        leds = 8'hE0; steps(3);
        chk("done_after_stop", 32'(done), 32'h1);
        leds = 8'h55; steps(4);
        chk("ignored_after_done", 32'(count), 32'h0);

        // Seventeen changes into a 16-deep FIFO with no consumer.
        ev_ready = 1'b0;
        pulse_clear();
        steps(2);
        for (int i = 0; i < 17; i++) begin
            leds = 8'(i + 1);
            steps(2);
        end
        steps(2);
        chk("overflow_count", 32'(count), 32'd16);
        chk("overflow_flag", 32'(overflow), 32'h1);

        // Full FIFO, push and pop on the same edge.
        pulse_clear();
        steps(2);
        for (int i = 0; i < 16; i++) begin
            leds = 8'(8'h21 + i);
            steps(2);
        end
        chk("full_before", 32'(count), 32'd16);
        leds = 8'h31;
        step();
        ev_ready = 1'b1;
        step();
        ev_ready = 1'b0;
        chk("full_pushpop_count", 32'(count), 32'd16);
        chk("full_pushpop_ovf", 32'(overflow), 32'h0);
        steps(2);

        // Changes 20 cycles apart; the 4-bit instance must wrap.
        pulse_clear();
        steps(2);
        leds = 8'hAA; steps(20);
        leds = 8'hBB; steps(4);
        ev_ready = 1'b1;
        steps(3);
        ev_ready = 1'b0;

        // Stop with three events queued, then clear.
        pulse_clear();
        steps(2);
        leds = 8'h01; steps(2);
        leds = 8'h02; steps(2);
        leds = 8'hE0; steps(3);
        chk("done_three_queued", 32'(done), 32'h1);
        chk("three_queued", 32'(count), 32'd3);
        pulse_clear();
        chk("clear_count", 32'(count), 32'h0);
        chk("clear_valid", 32'(ev_valid), 32'h0);
        chk("clear_done", 32'(done), 32'h0);
        chk("clear_ovf", 32'(overflow), 32'h0);

        // Random traffic with an asynchronous reset partway through.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(3) == 0)
                leds = ($urandom_range(7) == 0) ? 8'hE0 : 8'($urandom);
            ev_ready = 1'($urandom_range(1));
            enable   = ($urandom_range(15) != 0);
            clear    = ($urandom_range(99) == 0);
            if (i == 700) begin
                #2;
                rst_n = 1'b0;
                #1;
                check_reset_values();
                model_reset();
                #1;
                rst_n = 1'b1;
            end
            step();
        end
        clear = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/led_change_monitor.md
# led_change_monitor

Synthesizable LED-bus change monitor: samples a WIDTH-bit LED vector, records every change as a timestamped event in a DEPTH-entry FIFO, and stops capturing once a programmable terminal pattern is seen. Sits beside the SOC's LED output and feeds a UART/debug drain through a valid/ready port, giving on-chip the same "print on change, stop at pattern" behaviour the simulation benches give off-chip. Generalised in LED width, buffer depth, timestamp width and stop pattern.

## Interface
- WIDTH, 8, LED vector width (≥1)
- DEPTH, 16, event FIFO entries (power of two, ≥2)
- TS_WIDTH, 16, timestamp counter width
- STOP_PATTERN, 8'b11100000 (WIDTH bits), terminal pattern that ends capture
- CLK  in  1  single clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- LEDS  in  WIDTH  monitored LED vector (may be asynchronous, see Configuration)
- ENABLE  in  1  arm capture
- CLEAR  in  1  synchronous clear, highest priority after RESET
- EV_VALID  out  1  FIFO head valid
- EV_READY  in  1  consumer accepts head
- EV_DATA  out  TS_WIDTH+WIDTH  {timestamp, led_value} at FIFO head
- COUNT  out  $clog2(DEPTH)+1  FIFO occupancy
- DONE  out  1  stop pattern captured
- OVERFLOW  out  1  sticky: a change was dropped

## Operation
- Sample stage s: LEDS registered (1 flop, or 2 with macro). prev <= s every cycle. change = (s != prev) && state==ARMED.
- States: IDLE, ARMED, DONE.
  - IDLE: ts held at 0; ENABLE=1 -> ARMED at next edge.
  - ARMED: ts increments each cycle, wraps at 2^TS_WIDTH; on change push {ts, s}; if s==STOP_PATTERN on that push -> DONE (push happens even if FIFO full? no — see below); ENABLE=0 -> IDLE, ts cleared.
  - DONE: no captures, ts frozen, FIFO keeps draining; exit only via CLEAR or RESET.
- Stop check evaluated on change cycles only; DONE entered whether or not the stop event fit in the FIFO.
- Push accepted if COUNT<DEPTH, or COUNT==DEPTH with a pop in the same cycle. Otherwise event dropped, OVERFLOW set.
- Pop on EV_VALID && EV_READY. EV_DATA is show-ahead head; stable while EV_VALID && !EV_READY.
- Simultaneous push+pop: COUNT unchanged; push into empty FIFO with EV_READY high: not popped same cycle (EV_VALID was 0).
- CLEAR: FIFO emptied, OVERFLOW=0, DONE=0, ts=0, state -> IDLE; overrides push/pop that cycle.
- prev and s reset to 0: a non-zero LEDS at reset release produces a first event when armed.

## Timing
- Reset values: EV_VALID=0, EV_DATA=0, COUNT=0, DONE=0, OVERFLOW=0; state IDLE, ts=0, s=prev=0.
- Change latency (no macro): LEDS stable before edge k -> s updated at k -> push at k+1 -> EV_VALID=1 after k+1. Recorded ts = value during cycle k..k+1.
- DONE asserts after the same edge as the stop-pattern push.
- RESET mid-operation: all state cleared immediately, queued events lost.
- Changes shorter than one sample period may be missed; at most one event per cycle.

## Configuration
- LED_MON_SYNC_EN defined: LEDS passes a two-flop synchronizer (both flops reset to 0); change latency +1 cycle (push at k+2). Safe for asynchronous LEDS.
- Undefined: single sample register; LEDS must be synchronous to CLK.

## Test plan
- Reset, ENABLE=1, LEDS=8'h00 then 8'h01 held -> one event {ts, 8'h01}, EV_VALID two edges after change, COUNT=1.
- Step LEDS 01->03->07->0F->1F->3F->7F->E0, EV_READY=1 -> eight events in order, strictly increasing ts, DONE=1 after E0 event, later LEDS changes ignored.
- EV_READY=0, 17 distinct changes with DEPTH=16 -> COUNT=16, OVERFLOW=1, first 16 values retained in order.
- FIFO full, push and pop same cycle -> COUNT stays 16, OVERFLOW stays 0, new event at tail.
- TS_WIDTH=4, changes 20 cycles apart -> ts wraps (second ts = (first+20) mod 16).
- DONE with 3 events queued, CLEAR=1 one cycle -> COUNT=0, EV_VALID=0, DONE=0, OVERFLOW=0, state IDLE; assert RESET low mid-stream -> all outputs at reset values.
